instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state changes on rising edge when clk_enable=1.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high; forces reset state immediately.
REQ-003 SHALL have port: clk_enable  input  1  when 0, all registers hold.
REQ-004 SHALL have port: start  input  1  leaves IDLE when 1 on an enabled edge.
REQ-005 SHALL have port: read_address  output  6  address to instruction memory; equals PC.
REQ-006 SHALL have port: instruction_in  input  16  memory data, valid in the enabled cycle after the address edge.
REQ-007 SHALL have port: instr_out  output  16  registered instruction issued downstream.
REQ-008 SHALL have port: instr_valid  output  1  instr_out valid; held until accepted or squashed.
REQ-009 SHALL have port: instr_ready  input  1  downstream accepts instr_out when instr_valid=1.
REQ-010 SHALL have port: branch_taken  input  1  redirect request from execute.
REQ-011 SHALL have port: branch_target  input  6  redirect address.
REQ-012 SHALL have port: pc_out  output  6  address of the instruction in instr_out.
REQ-013 SHALL have port: halted  output  1  1 while FSM is in HALT.
REQ-014 SHALL have port: wrapped  output  1  sticky flag, PC incremented 63->0.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, WAIT, ISSUE, HALT; transitions only on edges with clk_enable=1.
REQ-016 SHALL go IDLE->FETCH when start=1; IDLE holds otherwise.
REQ-017 SHALL drive read_address=PC combinationally in every state.
REQ-018 SHALL go FETCH->WAIT unconditionally; memory captures address on this edge.
REQ-019 SHALL, in WAIT, load instr_out<=instruction_in, pc_out<=PC, then go ISSUE; fetch latency = 2 enabled cycles from FETCH entry to instr_valid=1.
REQ-020 SHALL assert instr_valid only in ISSUE.
REQ-021 SHALL, in ISSUE with instr_ready=1 and branch_taken=0, set PC<=PC+1 (6-bit modulo) and go FETCH.
REQ-022 SHALL, in ISSUE with instr_ready=0 and branch_taken=0, hold ISSUE with instr_out, pc_out stable.
REQ-023 SHALL, on branch_taken=1 in FETCH, WAIT or ISSUE, set PC<=branch_target, discard any in-flight or pending instruction, and go FETCH; branch has priority over instr_ready (instruction counts as accepted if instr_ready=1 that cycle).
REQ-024 SHALL ignore branch_taken in IDLE and HALT.
REQ-025 SHALL set wrapped<=1 when PC increments from 63 to 0; branch to 0 does not set it; cleared only by reset.
REQ-026 SHALL leave HALT only via reset.

Reset
REQ-027 SHALL, on reset=1, asynchronously set state=IDLE, PC=0, instr_out=16'h0000, pc_out=0, wrapped=0; thus instr_valid=0, halted=0, read_address=0.
REQ-028 SHALL, on reset mid-fetch, abandon the fetch with no instr_valid pulse; restart requires start.

Configuration
REQ-029 SHALL support macro FETCH_HALT_DETECT_EN: when defined, an instruction_in of 16'h0000 captured in WAIT sends the FSM to HALT instead of ISSUE (instr_out loaded, instr_valid stays 0, halted=1); when undefined, 16'h0000 is issued as a normal instruction and HALT is unreachable.

Verification
REQ-030 SHALL cover: reset, start=1, memory[0..2]=16'h4101,16'h4241,16'h0391, instr_ready=1 -> instr_valid every 3rd enabled cycle, pc_out 0,1,2, instr_out matches.
REQ-031 SHALL cover: instr_ready=0 for 5 cycles in ISSUE -> instr_out/pc_out stable, no PC advance; ready=1 -> PC+1.
REQ-032 SHALL cover: branch_taken=1, target=7 during WAIT of addr 3 -> no valid for addr 3; next issued pc_out=7.
REQ-033 SHALL cover: run from PC=63 with ready=1 -> next pc_out=0, wrapped=1 and stays 1.
REQ-034 SHALL cover: clk_enable=0 toggled every other cycle -> latency doubles in clk cycles, outputs unchanged while disabled; reset=1 mid-WAIT -> outputs at reset values same cycle.
REQ-035 SHALL cover: memory[4]=16'h0000 -> with FETCH_HALT_DETECT_EN halted=1, no valid; without, valid with instr_out=16'h0000.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: IDLE/FETCH/WAIT/ISSUE/HALT sequencer with a 6-bit PC and a one-cycle synchronous memory.
// Optional macro FETCH_HALT_DETECT_EN: a fetched 16'h0000 halts the unit instead of being issued.
module instruction_fetch (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        start,
    output logic [5:0]  read_address,
    input  logic [15:0] instruction_in,
    output logic [15:0] instr_out,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch_taken,
    input  logic [5:0]  branch_target,
    output logic [5:0]  pc_out,
    output logic        halted,
    output logic        wrapped
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [5:0]  pc_out_q, pc_out_d;
    logic        wrapped_q, wrapped_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            instr_q   <= '0;
            pc_out_q  <= '0;
            wrapped_q <= 1'b0;
        end else if (clk_enable) begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pc_out_q  <= pc_out_d;
            wrapped_q <= wrapped_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        pc_out_d  = pc_out_q;
        wrapped_d = wrapped_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (branch_taken) begin
                    pc_d    = branch_target;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A redirect here drops the word arriving from memory.
                if (branch_taken) begin
                    pc_d    = branch_target;
                    state_d = S_FETCH;
                end else begin
                    instr_d  = instruction_in;
                    pc_out_d = pc_q;
`ifdef FETCH_HALT_DETECT_EN
                    state_d  = (instruction_in == 16'h0000) ? S_HALT : S_ISSUE;
`else
                    state_d  = S_ISSUE;
`endif
                end
            end
            S_ISSUE: begin
                if (branch_taken) begin
                    pc_d    = branch_target;
                    state_d = S_FETCH;
                end else if (instr_ready) begin
                    pc_d    = pc_q + 6'd1;
                    state_d = S_FETCH;
                    if (pc_q == 6'd63) begin
                        wrapped_d = 1'b1;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign read_address = pc_q;
    assign instr_out    = instr_q;
    assign pc_out       = pc_out_q;
    assign wrapped      = wrapped_q;
    assign instr_valid  = (state_q == S_ISSUE);
    assign halted       = (state_q == S_HALT);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a one-cycle synchronous instruction memory model.
// Honours FETCH_HALT_DETECT_EN for the all-zero instruction case.
module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic        clk_enable;
    logic        start;
    logic [5:0]  read_address;
    logic [15:0] instruction_in;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_taken;
    logic [5:0]  branch_target;
    logic [5:0]  pc_out;
    logic        halted;
    logic        wrapped;

    int n_checks;
    int n_fail;

    instruction_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .clk_enable     (clk_enable),
        .start          (start),
        .read_address   (read_address),
        .instruction_in (instruction_in),
        .instr_out      (instr_out),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .pc_out         (pc_out),
        .halted         (halted),
        .wrapped        (wrapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [64];
    logic [15:0] mem_q;

    always @(posedge clk) begin
        if (clk_enable) begin
            mem_q <= mem[read_address];
        end
    end
    assign instruction_in = mem_q;

    typedef struct {
        logic        ce;
        logic        st;
        logic        rdy;
        logic        br;
        logic [5:0]  tgt;
        logic        ev;
        logic [15:0] ei;
        logic [5:0]  ep;
        logic [5:0]  er;
        logic        ew;
        logic        eh;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_outs(input string nm, input logic ev, input logic [15:0] ei,
                              input logic [5:0] ep, input logic [5:0] er,
                              input logic ew, input logic eh);
        chk({nm, ".instr_valid"},  {15'd0, instr_valid},  {15'd0, ev});
        chk({nm, ".instr_out"},    instr_out,             ei);
        chk({nm, ".pc_out"},       {10'd0, pc_out},       {10'd0, ep});
        chk({nm, ".read_address"}, {10'd0, read_address}, {10'd0, er});
        chk({nm, ".wrapped"},      {15'd0, wrapped},      {15'd0, ew});
        chk({nm, ".halted"},       {15'd0, halted},       {15'd0, eh});
    endtask

    task automatic step(input logic ce, input logic st, input logic rdy, input logic br,
                        input logic [5:0] tgt, input logic ev, input logic [15:0] ei,
                        input logic [5:0] ep, input logic [5:0] er,
                        input logic ew, input logic eh, input string nm);
        @(negedge clk);
        clk_enable    = ce;
        start         = st;
        instr_ready   = rdy;
        branch_taken  = br;
        branch_target = tgt;
        @(posedge clk);
        #1;
        check_outs(nm, ev, ei, ep, er, ew, eh);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int unsigned i = 0; i < 64; i++) begin
            mem[i] = 16'hC000 + 16'(i);
        end
        mem[0] = 16'h4101;
        mem[1] = 16'h4241;
        mem[2] = 16'h0391;
        mem[4] = 16'h0000;

        //           ce    st    rdy   br    tgt    ev    ei        ep    er    ew    eh
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 16'h0000, 6'd0, 6'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 16'h0000, 6'd0, 6'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b1, 16'h4101, 6'd0, 6'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 16'h4101, 6'd0, 6'd1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 16'h4101, 6'd0, 6'd1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b1, 16'h4241, 6'd1, 6'd1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 16'h4241, 6'd1, 6'd2, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 16'h4241, 6'd1, 6'd2, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b1, 16'h0391, 6'd2, 6'd2, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 16'h0391, 6'd2, 6'd2, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 16'h0391, 6'd2, 6'd2, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 16'h0391, 6'd2, 6'd2, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 16'h0391, 6'd2, 6'd2, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 16'h0391, 6'd2, 6'd2, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 16'h0391, 6'd2, 6'd3, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 16'h0391, 6'd2, 6'd3, 1'b0, 1'b0};

        reset         = 1'b1;
        clk_enable    = 1'b1;
        start         = 1'b0;
        instr_ready   = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 1'b0, 16'h0000, 6'd0, 6'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].ce, vecs[i].st, vecs[i].rdy, vecs[i].br, vecs[i].tgt,
                 vecs[i].ev, vecs[i].ei, vecs[i].ep, vecs[i].er, vecs[i].ew, vecs[i].eh,
                 $sformatf("vec%0d", i));
        end

        // Redirect during WAIT of address 3, then branch beats ready in ISSUE.
        step(1, 0, 0, 1, 6'd7,  0, 16'h0391, 6'd2,  6'd7,  0, 0, "br_wait");
        step(1, 0, 0, 0, 6'd0,  0, 16'h0391, 6'd2,  6'd7,  0, 0, "br_wait2");
        step(1, 0, 0, 0, 6'd0,  1, 16'hC007, 6'd7,  6'd7,  0, 0, "br_issue7");
        step(1, 0, 1, 1, 6'd62, 0, 16'hC007, 6'd7,  6'd62, 0, 0, "br_prio");
        step(1, 0, 1, 0, 6'd0,  0, 16'hC007, 6'd7,  6'd62, 0, 0, "w62_wait");
        step(1, 0, 1, 0, 6'd0,  1, 16'hC03E, 6'd62, 6'd62, 0, 0, "w62_issue");
        step(1, 0, 1, 0, 6'd0,  0, 16'hC03E, 6'd62, 6'd63, 0, 0, "w63_fetch");
        step(1, 0, 1, 0, 6'd0,  0, 16'hC03E, 6'd62, 6'd63, 0, 0, "w63_wait");
        step(1, 0, 1, 0, 6'd0,  1, 16'hC03F, 6'd63, 6'd63, 0, 0, "w63_issue");
        step(1, 0, 1, 0, 6'd0,  0, 16'hC03F, 6'd63, 6'd0,  1, 0, "wrap_fetch");
        step(1, 0, 1, 0, 6'd0,  0, 16'hC03F, 6'd63, 6'd0,  1, 0, "wrap_wait");
        step(1, 0, 1, 0, 6'd0,  1, 16'h4101, 6'd0,  6'd0,  1, 0, "wrap_issue");

        // Alternating clock enable.
        step(1, 0, 1, 0, 6'd0,  0, 16'h4101, 6'd0,  6'd1,  1, 0, "ce_fetch");
        step(0, 0, 1, 0, 6'd0,  0, 16'h4101, 6'd0,  6'd1,  1, 0, "ce_hold1");
        step(1, 0, 1, 0, 6'd0,  0, 16'h4101, 6'd0,  6'd1,  1, 0, "ce_wait");
        step(0, 0, 1, 0, 6'd0,  0, 16'h4101, 6'd0,  6'd1,  1, 0, "ce_hold2");
        step(1, 0, 1, 0, 6'd0,  1, 16'h4241, 6'd1,  6'd1,  1, 0, "ce_issue");
        step(0, 0, 1, 1, 6'd9,  1, 16'h4241, 6'd1,  6'd1,  1, 0, "ce_hold3");
        step(1, 0, 1, 0, 6'd0,  0, 16'h4241, 6'd1,  6'd2,  1, 0, "ce_fetch2");
        step(1, 0, 1, 0, 6'd0,  0, 16'h4241, 6'd1,  6'd2,  1, 0, "ce_wait2");

        // Asynchronous reset in WAIT, mid-cycle.
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_outs("rst_async", 1'b0, 16'h0000, 6'd0, 6'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_outs("rst_hold", 1'b0, 16'h0000, 6'd0, 6'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        step(1, 0, 1, 0, 6'd0,  0, 16'h0000, 6'd0,  6'd0,  0, 0, "idle_stay");
        step(1, 0, 1, 1, 6'd5,  0, 16'h0000, 6'd0,  6'd0,  0, 0, "idle_br");
        step(1, 1, 0, 0, 6'd0,  0, 16'h0000, 6'd0,  6'd0,  0, 0, "re_fetch");
        step(1, 0, 0, 0, 6'd0,  0, 16'h0000, 6'd0,  6'd0,  0, 0, "re_wait");
        step(1, 0, 0, 0, 6'd0,  1, 16'h4101, 6'd0,  6'd0,  0, 0, "re_issue");
        step(1, 0, 0, 1, 6'd0,  0, 16'h4101, 6'd0,  6'd0,  0, 0, "br0_fetch");
        step(1, 0, 0, 0, 6'd0,  0, 16'h4101, 6'd0,  6'd0,  0, 0, "br0_wait");
        step(1, 0, 0, 0, 6'd0,  1, 16'h4101, 6'd0,  6'd0,  0, 0, "br0_issue");
        step(1, 0, 0, 1, 6'd4,  0, 16'h4101, 6'd0,  6'd4,  0, 0, "z_fetch");
        step(1, 0, 0, 0, 6'd0,  0, 16'h4101, 6'd0,  6'd4,  0, 0, "z_wait");
`ifdef FETCH_HALT_DETECT_EN
        step(1, 0, 0, 0, 6'd0,  0, 16'h0000, 6'd4,  6'd4,  0, 1, "z_halt");
        step(1, 1, 1, 1, 6'd9,  0, 16'h0000, 6'd4,  6'd4,  0, 1, "z_halt_stay");
`else
        step(1, 0, 0, 0, 6'd0,  1, 16'h0000, 6'd4,  6'd4,  0, 0, "z_issue");
        step(1, 1, 1, 1, 6'd9,  0, 16'h0000, 6'd4,  6'd9,  0, 0, "z_branch");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
